seg7_reader: RTL
================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive equal registered samples required before a pattern is accepted (legal range 2..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports seg_a..seg_g  input  1 each  segment levels, active-high (1 = lit).
REQ-005 SHALL have port binary  output  3  decoded digit value.
REQ-006 SHALL have port out_valid  output  1  binary/seg_err hold a report.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the report.
REQ-008 SHALL have port seg_err  output  1  report is an illegal pattern; binary = 3'b000.

Function
REQ-009 SHALL register {a,b,c,d,e,f,g} into a sample register every cycle; all decoding uses registered samples only.
REQ-010 SHALL decode abcdefg patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
REQ-011 SHALL treat 0000000 as blank: never reported; on becoming stable it clears last-reported so the next digit is always reported.
REQ-012 SHALL treat any other pattern as illegal: reported with seg_err=1, binary=3'b000.
REQ-013 SHALL run a stability counter: cleared on sample change, incremented on equal sample, saturating at STABLE_CYCLES.
REQ-014 SHALL use FSM states IDLE (no report), SETTLE (counter running, pattern differs from last-reported), HOLD (out_valid=1).
REQ-015 SHALL transition IDLE->SETTLE on sample change; SETTLE->IDLE on counter saturating with blank or last-reported pattern; SETTLE->HOLD on saturating with any other pattern; HOLD->IDLE on out_valid&&out_ready.
REQ-016 SHALL, with inputs changed before edge 0 and held constant, assert out_valid after edge STABLE_CYCLES+1 (5 for default).
REQ-017 SHALL keep binary, seg_err, out_valid unchanged while out_valid=1 and out_ready=0, regardless of input changes.
REQ-018 SHALL update last-reported on the handshake edge; stability tracking continues during HOLD.
REQ-019 SHALL, after HOLD->IDLE, re-enter SETTLE the next cycle if the current stable sample differs from last-reported (pending pattern reported, intermediate ones may be skipped).
REQ-020 SHALL, when out_ready is held high, accept each report in its first valid cycle (out_valid high exactly one cycle).
REQ-021 SHALL report the same digit twice only if blank or a different pattern became stable between the two.

Reset
REQ-022 SHALL, while rst_n=0 at a clock edge, set binary=0, seg_err=0, out_valid=0, FSM=IDLE, counter=0, sample=0000000, last-reported=none.
REQ-023 SHALL abandon any SETTLE/HOLD state on reset mid-operation without issuing a report.
REQ-024 SHALL, after reset release, report the first stable non-blank pattern even if it equals the pre-reset one.

Configuration
REQ-025 SHALL, with SEG7_READER_ERRCNT_EN defined, add output err_cnt (8 bits): count of illegal reports accepted by handshake, saturating at 255, reset to 0.
REQ-026 SHALL, without SEG7_READER_ERRCNT_EN, have no err_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-027 SHALL place the eight digit pattern constants, blank constant and FSM state typedef in shared package seg7_pkg.
REQ-028 SHALL implement sample register plus stability counter as sub-module seg7_stable_filter (outputs: sample, stable, changed).

Verification
REQ-029 SHALL test: reset, hold 0110000 with out_ready=1 -> out_valid one cycle after edge 5, binary=001, seg_err=0.
REQ-030 SHALL test: 1101101 held, out_ready=0 for 10 cycles, inputs switched to 1111001 -> binary stays 010; after ready pulse, 011 reported next.
REQ-031 SHALL test: 1111001 held 3 cycles then 1011011 held -> only binary=101 reported.
REQ-032 SHALL test: 0110011 reported, blank stable, 0110011 again -> two reports of 100; without blank -> one report.
REQ-033 SHALL test: 1010101 held -> seg_err=1, binary=000; with SEG7_READER_ERRCNT_EN, err_cnt=1 after handshake.
REQ-034 SHALL test: rst_n low during HOLD -> out_valid=0 next edge; same pattern reported again after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the seven-segment reader.
//   SEG_* : abcdefg patterns for digits 0..7 plus the blank pattern
//           (bit 6 = segment a, bit 0 = segment g).
//   seg7_state_t  : reader FSM states.
//   seg7_decode_t : result of classifying one pattern.
//   seg7_decode() : pattern -> {blank, err, value}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seg7_state_t;

  typedef struct packed {
    logic       blank;
    logic       err;
    logic [2:0] value;
  } seg7_decode_t;

  // Illegal patterns decode to value 0 with err set, so the value can be
  // loaded into the report register unconditionally.
  function automatic seg7_decode_t seg7_decode(input logic [6:0] pat);
    seg7_decode_t d;
    d = '{blank: 1'b0, err: 1'b0, value: 3'd0};
    case (pat)
      SEG_BLANK: d.blank = 1'b1;
      SEG_0:     d.value = 3'd0;
      SEG_1:     d.value = 3'd1;
      SEG_2:     d.value = 3'd2;
      SEG_3:     d.value = 3'd3;
      SEG_4:     d.value = 3'd4;
      SEG_5:     d.value = 3'd5;
      SEG_6:     d.value = 3'd6;
      SEG_7:     d.value = 3'd7;
      default:   d.err   = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter -- sample register plus stability counter.
//   clk, rst_n : clock, synchronous active-low reset
//   seg        : raw segment levels {a,b,c,d,e,f,g}
//   sample     : registered copy of seg, updated every cycle
//   stable     : counter has saturated at STABLE_CYCLES (sample unchanged
//                for STABLE_CYCLES consecutive edges)
//   changed    : sample took a new value at the most recent edge
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [6:0] sample,
  output logic       stable,
  output logic       changed
);

  localparam logic [3:0] SAT = 4'(STABLE_CYCLES);

  logic [3:0] cnt;

  // The counter is updated on the same edge that loads the sample, so a
  // new value starts with cnt=0 and reaches SAT after STABLE_CYCLES more
  // equal samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample  <= 7'b0000000;
      cnt     <= 4'd0;
      changed <= 1'b0;
    end else begin
      sample  <= seg;
      changed <= (seg != sample);
      if (seg != sample) begin
        cnt <= 4'd0;
      end else if (cnt != SAT) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign stable = (cnt == SAT);

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader -- debounced seven-segment display reader.
//   Watches segments a..g, waits until a pattern has been stable for
//   STABLE_CYCLES cycles and reports it once as a 3-bit digit (or as an
//   illegal pattern with seg_err=1, binary=0). Blank is never reported but
//   re-arms reporting of the next digit.
//   clk, rst_n      : clock, synchronous active-low reset
//   seg_a..seg_g    : segment levels, 1 = lit
//   binary, seg_err : report contents, valid while out_valid=1
//   out_valid       : report available
//   out_ready       : consumer accepts the report
//   err_cnt         : illegal reports accepted, saturating at 255
//                     (only when SEG7_READER_ERRCNT_EN is defined)
//   fsm_state       : current FSM state, for debug/observation
//
// Handshake: a report is transferred on every rising edge where
// out_valid && out_ready. While out_valid=1 and out_ready=0, binary,
// seg_err and out_valid do not change whatever the segment inputs do.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seg_a,
  input  logic        seg_b,
  input  logic        seg_c,
  input  logic        seg_d,
  input  logic        seg_e,
  input  logic        seg_f,
  input  logic        seg_g,
  output logic [2:0]  binary,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        seg_err,
`ifdef SEG7_READER_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output seg7_state_t fsm_state
);

  logic [6:0]   sample;
  logic         stable;
  logic         changed;
  seg7_decode_t dec;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg     ({seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}),
    .sample  (sample),
    .stable  (stable),
    .changed (changed)
  );

  assign dec = seg7_decode(sample);

  seg7_state_t state, state_nxt;

  logic [6:0] rpt_pat;     // pattern currently held in the report
  logic [6:0] last_pat;    // pattern of the last accepted report
  logic       last_valid;  // 0 = nothing reported since reset/blank
  logic       load_rpt;
  logic       accept;
  logic       clear_last;
  logic       same_as_last;
  logic       pending;

  assign same_as_last = last_valid && (sample == last_pat);

  // A stable pattern still waiting to be reported: covers a value that
  // settled while a previous report was held, and a blank that must still
  // clear last-reported. Blank with nothing reported is already settled.
  assign pending = stable && !same_as_last && !(dec.blank && !last_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_rpt   = 1'b0;
    accept     = 1'b0;
    clear_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (changed || pending) begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (stable) begin
          if (dec.blank) begin
            clear_last = 1'b1;
            state_nxt  = ST_IDLE;
          end else if (same_as_last) begin
            state_nxt = ST_IDLE;
          end else begin
            load_rpt  = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          accept    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign out_valid = (state == ST_HOLD);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binary     <= 3'd0;
      seg_err    <= 1'b0;
      rpt_pat    <= 7'b0000000;
      last_pat   <= 7'b0000000;
      last_valid <= 1'b0;
    end else begin
      if (load_rpt) begin
        binary  <= dec.value;
        seg_err <= dec.err;
        rpt_pat <= sample;
      end
      if (accept) begin
        last_pat   <= rpt_pat;
        last_valid <= 1'b1;
      end
      if (clear_last) begin
        last_valid <= 1'b0;
      end
    end
  end

`ifdef SEG7_READER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (accept && seg_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
